// File: rtl/input_unit.sv
`default_nettype none
// ============================================================================
// Module      : input_unit
// Description : Router input-port flit buffer. Circular FIFO with credit
//               return pulse per pop; no write-to-head bypass.
//               Optional sticky overflow flag: INPUT_UNIT_OVERFLOW_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif
`ifndef CREDIT_CNT_WIDTH
`define CREDIT_CNT_WIDTH 4
`endif
`ifndef TOT_FIFO_DEPTH
`define TOT_FIFO_DEPTH 4
`endif
`ifndef LEVEL_ROOT
`define LEVEL_ROOT 0
`endif
`ifndef DIR_LOCAL
`define DIR_LOCAL 0
`endif

module input_unit #(
    parameter int level     = `LEVEL_ROOT,
    parameter int direction = `DIR_LOCAL,
    parameter int depth     = `TOT_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [`ROUTER_WIDTH-1:0]     in_data,
    input  logic                         in_data_valid,
    input  logic                         deq,
    output logic [`ROUTER_WIDTH-1:0]     head_data,
    output logic                         head_valid,
    output logic                         credit_out,
    output logic [`CREDIT_CNT_WIDTH-1:0] occupancy
`ifdef INPUT_UNIT_OVERFLOW_CHECK_EN
    ,
    output logic                         overflow_err
`endif
);

    localparam int                 c_data_w = `ROUTER_WIDTH;
    localparam int                 c_cnt_w  = `CREDIT_CNT_WIDTH;
    localparam int                 c_ptr_w  = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(depth);
    localparam logic [c_ptr_w-1:0] c_last   = c_ptr_w'(depth - 1);

    // Count must be able to hold the value depth itself.
    if (depth < 2 || depth > (1 << c_cnt_w) - 1) begin : g_depth_check
        $error("input_unit: depth %0d outside 2..%0d", depth, (1 << c_cnt_w) - 1);
    end

    if (level < 0 || direction < 0) begin : g_cfg_check
        $error("input_unit: level/direction must be non-negative");
    end

    logic [c_data_w-1:0] r_mem [depth];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_credit;

    logic w_pop;
    logic w_write;

    // A full buffer still accepts a flit when the head leaves in the same cycle.
    assign w_pop   = deq && (r_count != '0);
    assign w_write = in_data_valid && ((r_count != c_depth) || w_pop);

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_credit <= 1'b0;
        end else begin
            r_credit <= w_pop;
            if (w_write) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_valid = (r_count != '0);
    assign head_data  = r_mem[r_rd_ptr];
    assign occupancy  = r_count;
    assign credit_out = r_credit;

`ifdef INPUT_UNIT_OVERFLOW_CHECK_EN
    logic r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (in_data_valid && !w_write) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_err = r_overflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_input_unit.sv
`default_nettype none
// Testbench for input_unit (depth 4): queue-based reference model with
// directed fill/drain/wrap scenarios plus a randomized traffic phase.

`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif
`ifndef CREDIT_CNT_WIDTH
`define CREDIT_CNT_WIDTH 4
`endif

module tb_input_unit;

    localparam int W     = `ROUTER_WIDTH;
    localparam int CW    = `CREDIT_CNT_WIDTH;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_data_valid = 1'b0;
    logic          deq = 1'b0;
    logic [W-1:0]  head_data;
    logic          head_valid;
    logic          credit_out;
    logic [CW-1:0] occupancy;
`ifdef INPUT_UNIT_OVERFLOW_CHECK_EN
    logic          overflow_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    bit           exp_ovf = 1'b0;

    input_unit #(.depth(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_data_valid(in_data_valid),
        .deq          (deq),
        .head_data    (head_data),
        .head_valid   (head_valid),
        .credit_out   (credit_out),
        .occupancy    (occupancy)
`ifdef INPUT_UNIT_OVERFLOW_CHECK_EN
        ,
        .overflow_err (overflow_err)
`endif
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model applies the FIFO rules on the
    // pre-edge occupancy and reports whether a pop was due.
    task automatic step(input bit v, input logic [W-1:0] d, input bit dq, output bit popped);
        bit wr;
        in_data_valid = v;
        in_data       = d;
        deq           = dq;
        popped = dq && (exp_q.size() > 0);
        wr     = v && ((exp_q.size() < DEPTH) || popped);
        if (v && !wr) exp_ovf = 1'b1;
        if (popped) void'(exp_q.pop_front());
        if (wr) exp_q.push_back(d);
        @(posedge clk);
        #1;
        in_data_valid = 1'b0;
        deq           = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if (occupancy !== '0 || head_valid !== 1'b0 || credit_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: occ=%0d hv=%b cr=%b, want 0 0 0", occupancy, head_valid, credit_out);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
`ifdef INPUT_UNIT_OVERFLOW_CHECK_EN
        checks++;
        if (overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", overflow_err);
        end
`endif
    endtask

    task automatic test_fill();
        bit p;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, W'(8'hA1 + i), 1'b0, p);
            checks++;
            if (credit_out !== 1'b0) begin
                errors++;
                $display("FAIL fill_credit[%0d]: got %b want 0", i, credit_out);
            end
        end
        checks++;
        if (occupancy !== CW'(exp_q.size()) || head_valid !== 1'b1 || head_data !== W'(8'hA1)) begin
            errors++;
            $display("FAIL fill_state: occ=%0d hv=%b head=%h want %0d 1 a1",
                     occupancy, head_valid, head_data, exp_q.size());
        end
    endtask

    task automatic test_drain();
        bit p;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (head_valid !== 1'b1 || head_data !== exp_q[0]) begin
                errors++;
                $display("FAIL drain_head[%0d]: hv=%b head=%h want 1 %h", i, head_valid, head_data, exp_q[0]);
            end
            step(1'b0, '0, 1'b1, p);
            checks++;
            if (credit_out !== p) begin
                errors++;
                $display("FAIL drain_credit[%0d]: got %b want %b", i, credit_out, p);
            end
        end
        step(1'b0, '0, 1'b0, p);
        checks++;
        if (occupancy !== '0 || head_valid !== 1'b0 || credit_out !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: occ=%0d hv=%b cr=%b want 0 0 0", occupancy, head_valid, credit_out);
        end
    endtask

    task automatic test_full_simultaneous();
        bit p;
        for (int i = 0; i < DEPTH; i++) step(1'b1, W'(8'hA1 + i), 1'b0, p);
        step(1'b1, W'(8'hB5), 1'b1, p);
        checks++;
        if (credit_out !== 1'b1 || occupancy !== CW'(DEPTH) || head_data !== W'(8'hA2)) begin
            errors++;
            $display("FAIL full_simul: cr=%b occ=%0d head=%h want 1 %0d a2", credit_out, occupancy, head_data, DEPTH);
        end
        step(1'b0, '0, 1'b0, p);
        checks++;
        if (credit_out !== 1'b0) begin
            errors++;
            $display("FAIL full_simul_pulse: got %b want 0", credit_out);
        end
        while (exp_q.size() > 0) begin
            checks++;
            if (head_data !== exp_q[0]) begin
                errors++;
                $display("FAIL full_simul_order: got %h want %h", head_data, exp_q[0]);
            end
            step(1'b0, '0, 1'b1, p);
        end
        step(1'b0, '0, 1'b0, p);
    endtask

    task automatic test_wrap_empty();
        bit p;
        logic [W-1:0] d;
        for (int i = 0; i < 10; i++) begin
            d = W'($urandom);
            step(1'b1, d, 1'b0, p);
            checks++;
            if (head_valid !== 1'b1 || head_data !== d) begin
                errors++;
                $display("FAIL wrap_head[%0d]: hv=%b head=%h want 1 %h", i, head_valid, head_data, d);
            end
            step(1'b0, '0, 1'b1, p);
            step(1'b0, '0, 1'b1, p);
            checks++;
            if (credit_out !== 1'b0 || occupancy !== '0) begin
                errors++;
                $display("FAIL wrap_empty_deq[%0d]: cr=%b occ=%0d want 0 0", i, credit_out, occupancy);
            end
        end
    endtask

    task automatic test_random();
        bit p;
        for (int i = 0; i < 300; i++) begin
            checks++;
            if (occupancy !== CW'(exp_q.size()) || head_valid !== (exp_q.size() > 0)
                || (exp_q.size() > 0 && head_data !== exp_q[0])) begin
                errors++;
                $display("FAIL random_state[%0d]: occ=%0d hv=%b head=%h want occ %0d",
                         i, occupancy, head_valid, head_data, exp_q.size());
            end
            step(bit'($urandom_range(0, 1)), W'($urandom), bit'($urandom_range(0, 2) == 0), p);
            checks++;
            if (credit_out !== p) begin
                errors++;
                $display("FAIL random_credit[%0d]: got %b want %b", i, credit_out, p);
            end
        end
    endtask

    task automatic test_overflow();
        bit p;
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, W'(8'hA1 + i), 1'b0, p);
        step(1'b1, W'(8'hCC), 1'b0, p);
        step(1'b0, '0, 1'b0, p);
        checks++;
        if (occupancy !== CW'(DEPTH) || head_data !== W'(8'hA1) || credit_out !== 1'b0) begin
            errors++;
            $display("FAIL overflow_drop: occ=%0d head=%h cr=%b want %0d a1 0", occupancy, head_data, credit_out, DEPTH);
        end
`ifdef INPUT_UNIT_OVERFLOW_CHECK_EN
        checks++;
        if (overflow_err !== exp_ovf) begin
            errors++;
            $display("FAIL overflow_flag: got %b want %b", overflow_err, exp_ovf);
        end
`endif
        while (exp_q.size() > 0) begin
            checks++;
            if (head_data !== exp_q[0]) begin
                errors++;
                $display("FAIL overflow_order: got %h want %h", head_data, exp_q[0]);
            end
            step(1'b0, '0, 1'b1, p);
        end
`ifdef INPUT_UNIT_OVERFLOW_CHECK_EN
        checks++;
        if (overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b want 1", overflow_err);
        end
`endif
    endtask

    task automatic test_midstream_reset();
        bit p;
        for (int i = 0; i < 3; i++) step(1'b1, W'(8'hD0 + i), 1'b0, p);
        step(1'b0, '0, 1'b1, p);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (occupancy !== '0 || head_valid !== 1'b0 || credit_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset: occ=%0d hv=%b cr=%b want 0 0 0", occupancy, head_valid, credit_out);
        end
`ifdef INPUT_UNIT_OVERFLOW_CHECK_EN
        checks++;
        if (overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ovf: got %b want 0", overflow_err);
        end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        step(1'b1, W'(8'hE7), 1'b0, p);
        checks++;
        if (occupancy !== 1 || head_data !== W'(8'hE7) || credit_out !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: occ=%0d head=%h cr=%b want 1 e7 0", occupancy, head_data, credit_out);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_simultaneous();
        test_wrap_empty();
        test_random();
        test_overflow();
        test_midstream_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
